// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and state type for the systolic matmul sequencer.
package mm_pkg;

  // custom-0 major opcode claimed by the coprocessor
  localparam logic [6:0] MM_OPCODE = 7'b0001011;

  localparam logic [2:0] F3_WRITE = 3'b000;
  localparam logic [2:0] F3_CLEAR = 3'b101;
  localparam logic [2:0] F3_RUN   = 3'b111;
  localparam logic [2:0] F3_PERF  = 3'b010;

  // operand map inside the 5-bit address field
  localparam logic [4:0] A_BASE    = 5'd0;
  localparam logic [4:0] B_BASE    = 5'd9;
  localparam logic [4:0] BIAS_BASE = 5'd18;
  localparam logic [4:0] THR_ADDR  = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACK  = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } mm_state_t;

endpackage

// File: rtl/mm_feed_skew.sv
// mm_feed_skew: maps the run step to the skewed per-lane feed pattern.
// Lane r starts r steps late and consumes k = 0..N-1 on consecutive steps.
module mm_feed_skew #(
  parameter int N  = 3,
  parameter int SW = 3
) (
  input  logic [SW-1:0]  step,
  output logic [N-1:0]   feed_v,
  output logic [2*N-1:0] feed_k
);

  // per-lane window test: lane r is live while step lies in [r, r+N-1]
  always_comb begin
    feed_v = '0;
    feed_k = '0;
    for (int r = 0; r < N; r++) begin
      if ((int'(step) >= r) && ((int'(step) - r) < N)) begin
        feed_v[r]        = 1'b1;
        feed_k[2*r +: 2] = 2'(int'(step) - r);
      end
    end
  end

endmodule

// File: rtl/mm_sched.sv
// mm_sched: PCPI sequencer for the NxN systolic matmul coprocessor.
// Decodes custom-0 WRITE/CLEAR/RUN, drives the operand write port, steps the
// skewed feed and returns the captured compare bits.
// Optional feature: define MM_SCHED_PERF_EN for a 32-bit run counter read
// back with funct3 010.
module mm_sched
  import mm_pkg::*;
#(
  parameter int DW = 16,
  parameter int N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcpi_valid,
  input  logic [31:0]       pcpi_insn,
  output logic              pcpi_wr,
  output logic [31:0]       pcpi_rd,
  output logic              pcpi_wait,
  output logic              pcpi_ready,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [3:0]        wr_idx,
  output logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     thresh,
  output logic              arr_en,
  output logic              arr_clr,
  output logic [N-1:0]      feed_v,
  output logic [2*N-1:0]    feed_k,
  input  logic [N*N-1:0]    cmp_bits
);

  localparam int               STEP_W    = 3;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3*N-3);

  mm_state_t state_q, state_d;

  logic [STEP_W-1:0]     step_q, step_d;
  logic                  guard_q, guard_d;
  logic signed [DW-1:0]  thresh_q, thresh_d;
  logic [31:0]           rd_q, rd_d;
  logic [2:0]            f3_q, f3_d;
  logic [4:0]            addr_q, addr_d;
  logic signed [DW-1:0]  val_q, val_d;

  logic [6:0]            in_op;
  logic [2:0]            in_f3;
  logic [4:0]            in_addr;
  logic signed [15:0]    in_v16;
  logic signed [DW-1:0]  in_val;
  logic                  f3_ok;
  logic                  accept;
  logic [N-1:0]          skew_v;
  logic [2*N-1:0]        skew_k;
  logic                  unused_bits;

`ifdef MM_SCHED_PERF_EN
  logic [31:0]           cnt_q, cnt_d;
`endif

  assign in_op       = pcpi_insn[6:0];
  assign in_addr     = pcpi_insn[11:7];
  assign in_f3       = pcpi_insn[14:12];
  assign in_v16      = pcpi_insn[30:15];
  assign in_val      = DW'(in_v16);
  assign unused_bits = pcpi_insn[31];

`ifdef MM_SCHED_PERF_EN
  assign f3_ok = (in_f3 == F3_WRITE) || (in_f3 == F3_CLEAR) ||
                 (in_f3 == F3_RUN)   || (in_f3 == F3_PERF);
`else
  assign f3_ok = (in_f3 == F3_WRITE) || (in_f3 == F3_CLEAR) ||
                 (in_f3 == F3_RUN);
`endif

  // guard_q masks the IDLE cycle right after a completion while the core drops valid
  assign accept = (state_q == ST_IDLE) && pcpi_valid && (in_op == MM_OPCODE) &&
                  f3_ok && !guard_q;

  mm_feed_skew #(
    .N  (N),
    .SW (STEP_W)
  ) u_skew (
    .step   (step_q),
    .feed_v (skew_v),
    .feed_k (skew_k)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (in_f3 == F3_RUN) ? ST_RUN : ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      ST_RUN:  if (step_q == LAST_STEP) state_d = ST_CAPT;
      ST_CAPT: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // sequencing registers: step, guard, threshold, result (and run counter)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= '0;
      guard_q  <= 1'b0;
      thresh_q <= '0;
      rd_q     <= '0;
    end else begin
      step_q   <= step_d;
      guard_q  <= guard_d;
      thresh_q <= thresh_d;
      rd_q     <= rd_d;
    end
  end

`ifdef MM_SCHED_PERF_EN
  // run counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // latched instruction fields used during ACK; no reset needed, outputs are state-gated
  always_ff @(posedge clk) begin
    f3_q   <= f3_d;
    addr_q <= addr_d;
    val_q  <= val_d;
  end

  // next values for step counter, guard, threshold, result and latched fields
  always_comb begin
    step_d   = step_q;
    guard_d  = (state_q == ST_ACK) || (state_q == ST_DONE);
    thresh_d = thresh_q;
    rd_d     = rd_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    val_d    = val_q;
`ifdef MM_SCHED_PERF_EN
    cnt_d    = cnt_q;
`endif
    if (accept) begin
      f3_d   = in_f3;
      addr_d = in_addr;
      val_d  = in_val;
      step_d = '0;
      if (in_f3 != F3_RUN) rd_d = '0;
      if ((in_f3 == F3_WRITE) && (in_addr == THR_ADDR)) thresh_d = in_val;
      if (in_f3 == F3_CLEAR) begin
        thresh_d = '0;
`ifdef MM_SCHED_PERF_EN
        cnt_d    = '0;
`endif
      end
`ifdef MM_SCHED_PERF_EN
      if (in_f3 == F3_PERF) rd_d = cnt_q;
`endif
    end
    if (state_q == ST_RUN) step_d = step_q + STEP_W'(1);
    if (state_q == ST_CAPT) begin
      rd_d = 32'(cmp_bits);
`ifdef MM_SCHED_PERF_EN
      cnt_d = cnt_q + 32'd1;
`endif
    end
  end

  // output decode from state
  always_comb begin
    pcpi_wr    = 1'b0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = 2'd0;
    wr_idx     = 4'd0;
    wr_data    = '0;
    arr_en     = 1'b0;
    arr_clr    = 1'b0;
    feed_v     = '0;
    feed_k     = '0;
    case (state_q)
      ST_ACK: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        if ((f3_q == F3_WRITE) && (addr_q < THR_ADDR)) begin
          wr_en   = 1'b1;
          wr_data = val_q;
          if (addr_q < B_BASE) begin
            wr_sel = 2'd0;
            wr_idx = 4'(addr_q - A_BASE);
          end else if (addr_q < BIAS_BASE) begin
            wr_sel = 2'd1;
            wr_idx = 4'(addr_q - B_BASE);
          end else begin
            wr_sel = 2'd2;
            wr_idx = 4'(addr_q - BIAS_BASE);
          end
        end
      end
      ST_RUN: begin
        pcpi_wait = 1'b1;
        arr_en    = 1'b1;
        arr_clr   = (step_q == '0);
        feed_v    = skew_v;
        feed_k    = skew_k;
      end
      ST_CAPT: pcpi_wait = 1'b1;
      ST_DONE: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcpi_rd = rd_q;
  assign thresh  = thresh_q;

endmodule
